seq_divider_16bit: RTL and testbench

- Multi-cycle 16-bit restoring divider that performs the inverse of the datapath adder/subtractor.
- Each iteration does one shift-and-trial-subtract through the same two's-complement subtract path: B inverted, carry-in 1.
- Serves DIV/REM instructions whose results are not ready within one cycle. The controller holds the pipeline on busy and captures the result on done.

---
 rtl/seq_divider_16bit.sv | 131 +++++++++++++
 tb/tb_seq_divider_16bit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/seq_divider_16bit.sv
// Multi-cycle restoring divider: one shift-and-trial-subtract per clock, 17 cycles
// from accept to done, with divide-by-zero and signed-overflow results fixed up at the end.
module seq_divider_16bit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem, dvd, quo, dvsr, a_r, b_r;
  logic             sgn_r, sa, sb;

  logic             accept, last_iter, finish;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   shifted, trial;
  logic             no_borrow;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic             dz_fix, ovf_fix;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last_iter) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control and result-fixup logic
  always_comb begin
    accept    = (state == IDLE) && start;
    last_iter = (state == CALC) && (cnt == CNT_W'(WIDTH - 1));
    finish    = (state == FIX);

    abs_a = (sgn && A[WIDTH-1]) ? (~A + 1'b1) : A;
    abs_b = (sgn && B[WIDTH-1]) ? (~B + 1'b1) : B;

    // Full 17-bit partial remainder: divisors >= 2^(WIDTH-1) need the carried-out MSB.
    shifted              = {rem, dvd[WIDTH-1]};
    {no_borrow, trial}   = {1'b0, shifted} + {1'b0, ~{1'b0, dvsr}} + (WIDTH+2)'(1);

    dz_fix  = (b_r == '0);
    ovf_fix = !dz_fix && sgn_r && (a_r == {1'b1, {(WIDTH-1){1'b0}}}) && (b_r == '1);

    if (dz_fix) begin
      q_fix = '1;
      r_fix = a_r;
    end else if (ovf_fix) begin
      q_fix = {1'b1, {(WIDTH-1){1'b0}}};
      r_fix = '0;
    end else begin
      q_fix = (sgn_r && (sa ^ sb)) ? (~quo + 1'b1) : quo;
      r_fix = (sgn_r && sa)        ? (~rem + 1'b1) : rem;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      rem   <= '0;
      dvd   <= '0;
      quo   <= '0;
      dvsr  <= '0;
      a_r   <= '0;
      b_r   <= '0;
      sgn_r <= 1'b0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      Q     <= '0;
      R     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      dz    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= finish;
      if (accept) begin
        sgn_r <= sgn;
        sa    <= sgn & A[WIDTH-1];
        sb    <= sgn & B[WIDTH-1];
        a_r   <= A;
        b_r   <= B;
        dvd   <= abs_a;
        dvsr  <= abs_b;
        rem   <= '0;
        quo   <= '0;
        cnt   <= '0;
        busy  <= 1'b1;
      end
      if (state == CALC) begin
        dvd <= dvd << 1;
        quo <= {quo[WIDTH-2:0], no_borrow};
        rem <= no_borrow ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        cnt <= cnt + 1'b1;
      end
      if (finish) begin
        Q    <= q_fix;
        R    <= r_fix;
        dz   <= dz_fix;
        ovf  <= ovf_fix;
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider_16bit.sv
// Scoreboard bench for seq_divider_16bit: expected results are queued at each accept
// and compared (value, flags, latency) when done pulses.
module tb_seq_divider_16bit;

  logic        clk, rst, start, sgn;
  logic [15:0] A, B, Q, R;
  logic        busy, done, dz, ovf;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;

  typedef struct {
    logic [15:0] a, b, q, r;
    logic        dz, ovf;
    int unsigned dc;
  } exp_t;

  exp_t sb[$];

  seq_divider_16bit #(.WIDTH(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .sgn(sgn), .A(A), .B(B),
    .Q(Q), .R(R), .busy(busy), .done(done), .dz(dz), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic s);
    exp_t e;
    int ia, ib;
    e.a = a; e.b = b; e.dz = 1'b0; e.ovf = 1'b0; e.dc = 0;
    if (b == 16'h0) begin
      e.q = 16'hFFFF; e.r = a; e.dz = 1'b1;
    end else if (s && a == 16'h8000 && b == 16'hFFFF) begin
      e.q = 16'h8000; e.r = 16'h0; e.ovf = 1'b1;
    end else begin
      ia = s ? int'($signed(a)) : int'(a);
      ib = s ? int'($signed(b)) : int'(b);
      e.q = 16'(ia / ib);
      e.r = 16'(ia % ib);
    end
    return e;
  endfunction

  // Monitor: compare on done, flag spurious done and overdue results.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'(done), 32'd0);
      end else begin
        e = sb.pop_front();
        check("Q", 32'(Q), 32'(e.q));
        check("R", 32'(R), 32'(e.r));
        check("dz", 32'(dz), 32'(e.dz));
        check("ovf", 32'(ovf), 32'(e.ovf));
        check("latency", cyc, e.dc);
        check("busy_at_done", 32'(busy), 32'd0);
        if (!e.dz && !e.ovf) check("invariant", 32'(16'(Q * e.b + R)), 32'(e.a));
      end
    end else if (sb.size() != 0 && cyc > sb[0].dc) begin
      check("timeout", cyc, sb[0].dc);
      void'(sb.pop_front());
    end
  end

  // Present a request; returns after the accept edge with the expectation queued.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s);
    exp_t e;
    @(negedge clk);
    A = a; B = b; sgn = s; start = 1'b1;
    @(posedge clk);
    #1;
    e = model(a, b, s);
    e.dc = cyc + 17;
    sb.push_back(e);
    start = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #2;
    end
    check("drain", sb.size(), 0);
  endtask

  task automatic op(input logic [15:0] a, input logic [15:0] b, input logic s);
    issue(a, b, s);
    drain();
  endtask

  initial begin
    exp_t e;
    logic [15:0] ra, rb;
    rst = 1'b1; start = 1'b0; sgn = 1'b0; A = '0; B = '0;
    #12;
    check("rst_Q", 32'(Q), 32'd0);
    check("rst_R", 32'(R), 32'd0);
    check("rst_flags", {28'd0, busy, done, dz, ovf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    op(16'd100, 16'd7, 1'b0);
    op(16'hFF9C, 16'd7, 1'b1);
    op(16'd100, 16'hFFF9, 1'b1);
    op(16'h1234, 16'h0000, 1'b0);
    op(16'h8000, 16'hFFFF, 1'b1);
    op(16'h8000, 16'hFFFF, 1'b0);
    op(16'hFFFF, 16'd1, 1'b0);
    op(16'hFFFF, 16'h8001, 1'b0);
    op(16'hFFFE, 16'hFFFF, 1'b0);
    op(16'h8000, 16'd0, 1'b1);

    // Start while busy must be ignored.
    issue(16'd1000, 16'd3, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    A = 16'd1; B = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (25) @(posedge clk);

    // Start held high: one accept every 18 cycles.
    @(negedge clk);
    A = 16'd5000; B = 16'd13; sgn = 1'b0; start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      e = model(16'd5000, 16'd13, 1'b0);
      e.dc = cyc + 17;
      sb.push_back(e);
      if (k == 2) start = 1'b0;
      else repeat (17) @(posedge clk);
    end
    drain();

    // Asynchronous reset mid-operation discards the result.
    issue(16'd1000, 16'd7, 1'b0);
    repeat (8) @(posedge clk);
    #3;
    rst = 1'b1;
    sb.delete();
    #1;
    check("midrst_Q", 32'(Q), 32'd0);
    check("midrst_R", 32'(R), 32'd0);
    check("midrst_flags", {28'd0, busy, done, dz, ovf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(posedge clk);
    op(16'd255, 16'd16, 1'b0);

    // Random back-to-back traffic with occasional corner operands.
    for (int n = 0; n < 2000; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 15))
        0: rb = 16'h0000;
        1: begin ra = 16'h8000; rb = 16'hFFFF; end
        2: rb = 16'($urandom_range(1, 15));
        3: rb = 16'hFFFF;
        default: ;
      endcase
      op(ra, rb, 1'($urandom));
    end

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
